// File: rtl/edge_row_packer.sv
// edge_row_packer: packs the serial edge-bit stream into per-row words,
// queues them in a small show-ahead FIFO and offers them on valid/ready.
// The edge source cannot stall, so a row that finds the FIFO full is
// dropped and a sticky overflow flag is raised instead.
module edge_row_packer #(
    parameter int IMG_DIM    = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               edge_in,
    input  logic               edge_valid,
    input  logic               clear,
    output logic [IMG_DIM-1:0] row_data,
    output logic [IDX_W-1:0]   row_idx,
    output logic               row_valid,
    input  logic               row_ready,
    output logic               frame_done,
    output logic               overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = IMG_DIM + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_DIM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     col_reg, row_reg;
    logic [IMG_DIM-1:0]   partial_reg;
    logic [IMG_DIM-1:0]   row_word;
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 overflow_reg;
    logic [WORD_W-1:0]    mem [FIFO_DEPTH];
    logic [WORD_W-1:0]    head;

    logic accept, row_end, frame_end;
    logic fifo_empty, fifo_full, pop, push_ok, drop;

    // clear wins over a bit arriving in the same cycle
    assign accept    = edge_valid & ~clear;
    assign row_end   = accept & (col_reg == LAST_IDX);
    assign frame_end = row_end & (row_reg == LAST_IDX);

    // Partial row with the incoming bit merged in at the current column
    genvar gi;
    generate
        for (gi = 0; gi < IMG_DIM; gi++) begin : g_bit
            assign row_word[gi] = (col_reg == IDX_W'(gi)) ? edge_in : partial_reg[gi];
        end
    endgenerate

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop        = ~fifo_empty & row_ready & ~clear;
    // A pop on the same edge frees the slot, so a full FIFO still accepts
    assign push_ok    = row_end & (~fifo_full | pop);
    assign drop       = row_end & fifo_full & ~pop;
    assign head       = mem[rd_ptr_reg];

    // Column/row counters and the partial-row shift target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_reg     <= '0;
            row_reg     <= '0;
            partial_reg <= '0;
        end else if (clear) begin
            col_reg     <= '0;
            row_reg     <= '0;
            partial_reg <= '0;
        end else if (accept) begin
            if (col_reg == LAST_IDX) begin
                col_reg     <= '0;
                partial_reg <= '0;
                row_reg     <= (row_reg == LAST_IDX) ? '0 : row_reg + IDX_W'(1);
            end else begin
                col_reg     <= col_reg + IDX_W'(1);
                partial_reg <= row_word;
            end
        end
    end

    // FIFO storage; contents are only meaningful where count says so
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= {row_reg, row_word};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky overflow on a dropped row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_reg <= 1'b0;
        end else if (clear) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Frame FSM next-state logic
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept) state_next = frame_end ? DONE : RECV;
                RECV:    if (frame_end) state_next = DONE;
                DONE:    state_next = accept ? (frame_end ? DONE : RECV) : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs: frame pulse from FSM, show-ahead head gated by occupancy
    always_comb begin
        frame_done = (state_reg == DONE);
        overflow   = overflow_reg;
        row_valid  = ~fifo_empty;
        row_data   = '0;
        row_idx    = '0;
        if (!fifo_empty) begin
            row_data = head[IMG_DIM-1:0];
            row_idx  = head[WORD_W-1:IMG_DIM];
        end
    end

endmodule
